vec_issue_sequencer: RTL and testbench
======================================

// Module: vec_issue_sequencer
// PURPOSE
//   Multi-cycle decode/issue stage for the vector extension. Accepts one instruction (Op/Funct/Rd)
//   per valid/ready handshake, decodes it, and issues it to the ALU datapath as one beat
//   (scalar op, MOVIDX) or as NLANES/LANES_PER_BEAT lane-group beats (vector op), with downstream backpressure.
//   Sits between instruction fetch/register read and the lane-sliced vector ALU.
// PARAMETERS
//   NLANES          4   vector lanes per register; power of 2, >=2
//   LANES_PER_BEAT  1   lanes issued per beat; power of 2, divides NLANES
//   LANE_W          8   lane width in bits; vector register width = NLANES*LANE_W
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       asynchronous, active-low reset
//   in_valid       in   1       instruction offered
//   in_ready       out  1       instruction accepted when in_valid & in_ready
//   Op             in   2       instruction Op field
//   Funct          in   6       instruction Funct field (Funct[0] = S bit)
//   Rd             in   4       destination register
//   iss_valid      out  1       issue beat valid
//   iss_ready      in   1       downstream accepts beat
//   iss_lane_mask  out  NLANES  lanes active this beat (one-hot group)
//   iss_ALUControl out  4       ALU operation for this beat
//   iss_VecW       out  1       vector register write for active lanes
//   iss_VecIdxW    out  1       MOVIDX: write scalar into lane Rd[log2(NLANES)-1:0]
//   iss_RegW       out  1       scalar register write
//   iss_FlagW      out  2       flag write enables (scalar ops only)
//   iss_last       out  1       final beat of current instruction
//   illegal        out  1       one-cycle pulse: Op==2'b11 accepted and dropped
// BEHAVIOUR
//   - Reset (async, low): state IDLE; all outputs 0 except in_ready=1; captured fields and lane counter 0.
//     Reset mid-instruction abandons remaining beats; nothing is issued after release until a new accept.
//   - FSM: IDLE, ISSUE. in_ready = IDLE | (iss_valid & iss_ready & iss_last): back-to-back
//     accept on the last-beat handshake, zero bubble. Accept registers Op/Funct/Rd; iss_valid rises next cycle.
//   - Classification of accepted word:
//       Op=00, Funct[5]=1, Funct[4:1]=1101 : MOVIDX, 1 beat, VecIdxW=1, mask=0
//       Op=00, Funct[5]=1, Funct[4:1]=1110 : MOV, 1 beat, RegW=1, ALUControl=0000
//       Op=00, Funct[4]=1 (other)           : vector op, NLANES/LANES_PER_BEAT beats, VecW=1
//       Op=00, Funct[4]=0                    : scalar DP, 1 beat, RegW=1
//       Op=01/10                            : memory/branch, 1 beat, ALUControl=0000, RegW=~Op[1] & Funct[0]
//       Op=11                               : illegal; stay IDLE, pulse illegal next cycle, no beat
//   - ALUControl by Funct[4:1]: 0100->0000 ADD, 0101->0001 SUB, 0010->0010 AND, 0000->0011 ORR,
//     0011->0111 XOR, 0111->1100 FADD, 0110->0101 FMUL, 1000->1000 VADD, 1001->1001 VSUB,
//     1010->1010 VAND, 1011->1011 VORR, 1111->1111 VXOR, 1100->1101 VADDFP; Op!=00 -> 0000.
//   - FlagW (scalar DP only): [1]=Funct[0]; [0]=Funct[0] & (ALUControl==0000|0001). Vector/MOVIDX/MOV: 00.
//   - Lane counter: beat k mask = ((1<<LANES_PER_BEAT)-1) << (k*LANES_PER_BEAT); advances only on
//     iss_valid & iss_ready; iss_last on beat NLANES/LANES_PER_BEAT-1 (or the single beat).
//   - Hold rule: while iss_valid & ~iss_ready every iss_* output is stable.
//   - Counter wraps to 0 after last beat; when NLANES==LANES_PER_BEAT vector ops are single-beat.
//   - Rd==4'b1111 with RegW: issued normally; PC update is handled downstream.
// TESTING
//   1 Reset low mid-VADD beat 2 -> in_ready=1, iss_valid=0 immediately; after release no stale beats.
//   2 NLANES=4, LPB=1, VADD (Op=00, Funct=010000), iss_ready=1 -> 4 beats, masks 0001,0010,0100,1000,
//     ALUControl=1000, VecW=1, iss_last on 4th only; next instr accepted on 4th beat cycle.
//   3 Same VADD, iss_ready low 3 cycles at beat 2 -> mask 0010 held stable, total 7 valid cycles.
//   4 SUBS (Op=00, Funct=001011) -> 1 beat, ALUControl=0001, FlagW=11, RegW=1, iss_last=1.
//   5 MOVIDX (Funct=111010, Rd=0010) -> 1 beat, VecIdxW=1, VecW=0, mask=0000; Op=11 -> illegal pulse, no beat.
//   6 NLANES=8, LPB=2, VXOR (Funct=011110) -> 4 beats, masks 03,0C,30,C0, ALUControl=1111.

Source files
------------

// File: rtl/vec_issue_sequencer.sv
// vec_issue_sequencer
//   Decode/issue stage for the vector extension. Accepts one instruction per
//   in_valid/in_ready handshake, decodes it, and issues it to the lane-sliced
//   ALU as one beat (scalar, MOV, MOVIDX, memory/branch) or as
//   NLANES/LANES_PER_BEAT lane-group beats (vector ops).
// Ports
//   clk, reset (async, active-low)
//   in_valid/in_ready, Op/Funct/Rd          : instruction input handshake
//   iss_valid/iss_ready                      : issue beat handshake
//   iss_lane_mask, iss_ALUControl, iss_VecW, iss_VecIdxW, iss_RegW,
//   iss_FlagW, iss_last                      : beat payload
//   illegal                                  : one-cycle pulse for a dropped Op==11
module vec_issue_sequencer #(
    parameter int unsigned NLANES         = 4,
    parameter int unsigned LANES_PER_BEAT = 1,
    parameter int unsigned LANE_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [NLANES-1:0] iss_lane_mask,
    output logic [3:0]        iss_ALUControl,
    output logic              iss_VecW,
    output logic              iss_VecIdxW,
    output logic              iss_RegW,
    output logic [1:0]        iss_FlagW,
    output logic              iss_last,
    output logic              illegal
);

    localparam int unsigned NBEATS = NLANES / LANES_PER_BEAT;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(NBEATS - 1);
    localparam logic [NLANES-1:0] GROUP_MASK = NLANES'((64'd1 << LANES_PER_BEAT) - 64'd1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    // Elaboration-time guard on the parameter set
    if (NLANES < 2 || (NLANES & (NLANES - 1)) != 0 || LANES_PER_BEAT < 1 ||
        (LANES_PER_BEAT & (LANES_PER_BEAT - 1)) != 0 ||
        (NLANES % LANES_PER_BEAT) != 0 || LANE_W < 1) begin : g_bad_params
        $error("vec_issue_sequencer: illegal parameter set");
    end

    logic [0:0]       r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic [3:0]       r_alu, w_nxt_alu;
    logic             r_vec, w_nxt_vec;
    logic             r_vecw, w_nxt_vecw;
    logic             r_vecidxw, w_nxt_vecidxw;
    logic             r_regw, w_nxt_regw;
    logic [1:0]       r_flagw, w_nxt_flagw;
    logic             r_illegal, w_nxt_illegal;

    logic             w_last, w_hs, w_accept;
    logic [3:0]       w_tab_alu, w_d_alu;
    logic             w_d_vec, w_d_vecw, w_d_vecidxw, w_d_regw, w_d_ill;
    logic [1:0]       w_d_flagw;

    // Rd has no consumer on the issue side of this port set
    logic             w_unused_rd;
    assign w_unused_rd = ^Rd;

    // Handshake: accept in IDLE or on the last-beat handshake (zero bubble)
    assign w_last    = ~r_vec | (r_cnt == LAST_BEAT);
    assign w_hs      = (r_state == S_ISSUE) & iss_ready;
    assign in_ready  = (r_state == S_IDLE) | (w_hs & w_last);
    assign w_accept  = in_valid & in_ready;

    // Funct[4:1] to ALU operation
    always_comb begin
        w_tab_alu = 4'b0000;
        case (Funct[4:1])
            4'b0100: w_tab_alu = 4'b0000;
            4'b0101: w_tab_alu = 4'b0001;
            4'b0010: w_tab_alu = 4'b0010;
            4'b0000: w_tab_alu = 4'b0011;
            4'b0011: w_tab_alu = 4'b0111;
            4'b0111: w_tab_alu = 4'b1100;
            4'b0110: w_tab_alu = 4'b0101;
            4'b1000: w_tab_alu = 4'b1000;
            4'b1001: w_tab_alu = 4'b1001;
            4'b1010: w_tab_alu = 4'b1010;
            4'b1011: w_tab_alu = 4'b1011;
            4'b1111: w_tab_alu = 4'b1111;
            4'b1100: w_tab_alu = 4'b1101;
            default: w_tab_alu = 4'b0000;
        endcase
    end

    // Instruction classification of the offered word
    always_comb begin
        w_d_alu     = 4'b0000;
        w_d_vec     = 1'b0;
        w_d_vecw    = 1'b0;
        w_d_vecidxw = 1'b0;
        w_d_regw    = 1'b0;
        w_d_flagw   = 2'b00;
        w_d_ill     = (Op == 2'b11);
        if (Op == 2'b00) begin
            if (Funct[5] && Funct[4:1] == 4'b1101) begin
                w_d_vecidxw = 1'b1;
            end else if (Funct[5] && Funct[4:1] == 4'b1110) begin
                w_d_regw = 1'b1;
            end else if (Funct[4]) begin
                w_d_vec  = 1'b1;
                w_d_vecw = 1'b1;
                w_d_alu  = w_tab_alu;
            end else begin
                w_d_regw  = 1'b1;
                w_d_alu   = w_tab_alu;
                w_d_flagw = {Funct[0],
                             Funct[0] & ((w_tab_alu == 4'b0000) | (w_tab_alu == 4'b0001))};
            end
        end else if (Op != 2'b11) begin
            w_d_regw = ~Op[1] & Funct[0];
        end
    end

    // Next-state and captured-field logic
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_alu     = r_alu;
        w_nxt_vec     = r_vec;
        w_nxt_vecw    = r_vecw;
        w_nxt_vecidxw = r_vecidxw;
        w_nxt_regw    = r_regw;
        w_nxt_flagw   = r_flagw;
        w_nxt_illegal = 1'b0;
        if (w_hs) begin
            if (w_last) begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
            end
        end
        if (w_accept) begin
            if (w_d_ill) begin
                w_nxt_illegal = 1'b1;
            end else begin
                w_nxt_state   = S_ISSUE;
                w_nxt_cnt     = '0;
                w_nxt_alu     = w_d_alu;
                w_nxt_vec     = w_d_vec;
                w_nxt_vecw    = w_d_vecw;
                w_nxt_vecidxw = w_d_vecidxw;
                w_nxt_regw    = w_d_regw;
                w_nxt_flagw   = w_d_flagw;
            end
        end
    end

    // State and captured-field registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_alu     <= 4'b0000;
            r_vec     <= 1'b0;
            r_vecw    <= 1'b0;
            r_vecidxw <= 1'b0;
            r_regw    <= 1'b0;
            r_flagw   <= 2'b00;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_alu     <= w_nxt_alu;
            r_vec     <= w_nxt_vec;
            r_vecw    <= w_nxt_vecw;
            r_vecidxw <= w_nxt_vecidxw;
            r_regw    <= w_nxt_regw;
            r_flagw   <= w_nxt_flagw;
            r_illegal <= w_nxt_illegal;
        end
    end

    // Beat payload is quiet whenever no beat is offered
    assign iss_valid      = (r_state == S_ISSUE);
    assign iss_lane_mask  = (iss_valid & r_vec) ? (GROUP_MASK << (32'(r_cnt) * LANES_PER_BEAT))
                                                : '0;
    assign iss_ALUControl = iss_valid ? r_alu : 4'b0000;
    assign iss_VecW       = iss_valid & r_vecw;
    assign iss_VecIdxW    = iss_valid & r_vecidxw;
    assign iss_RegW       = iss_valid & r_regw;
    assign iss_FlagW      = iss_valid ? r_flagw : 2'b00;
    assign iss_last       = iss_valid & w_last;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Self-checking bench for vec_issue_sequencer: directed cases plus randomized
// instructions checked against a table-driven reference model.
module tb_vec_issue_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, iss_valid, iss_ready;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] iss_lane_mask, iss_ALUControl;
    logic       iss_VecW, iss_VecIdxW, iss_RegW, iss_last, illegal;
    logic [1:0] iss_FlagW;

    logic       in_valid8, in_ready8, iss_valid8, iss_ready8;
    logic [1:0] Op8;
    logic [5:0] Funct8;
    logic [3:0] Rd8;
    logic [7:0] iss_lane_mask8;
    logic [3:0] iss_ALUControl8;
    logic       iss_VecW8, iss_VecIdxW8, iss_RegW8, iss_last8, illegal8;
    logic [1:0] iss_FlagW8;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    vec_issue_sequencer #(.NLANES(4), .LANES_PER_BEAT(1), .LANE_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Op(Op), .Funct(Funct), .Rd(Rd), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_lane_mask(iss_lane_mask), .iss_ALUControl(iss_ALUControl),
        .iss_VecW(iss_VecW), .iss_VecIdxW(iss_VecIdxW), .iss_RegW(iss_RegW),
        .iss_FlagW(iss_FlagW), .iss_last(iss_last), .illegal(illegal));

    vec_issue_sequencer #(.NLANES(8), .LANES_PER_BEAT(2), .LANE_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .Op(Op8), .Funct(Funct8), .Rd(Rd8), .iss_valid(iss_valid8), .iss_ready(iss_ready8),
        .iss_lane_mask(iss_lane_mask8), .iss_ALUControl(iss_ALUControl8),
        .iss_VecW(iss_VecW8), .iss_VecIdxW(iss_VecIdxW8), .iss_RegW(iss_RegW8),
        .iss_FlagW(iss_FlagW8), .iss_last(iss_last8), .illegal(illegal8));

    // Reference ALU encoding indexed by Funct[4:1]
    localparam logic [3:0] ALU_TAB [16] = '{
        4'b0011, 4'b0000, 4'b0010, 4'b0111, 4'b0000, 4'b0001, 4'b0101, 4'b1100,
        4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b0000, 4'b0000, 4'b1111};

    typedef struct {
        int         beats;
        bit         vec;
        logic [3:0] alu;
        logic       vecw, vecidxw, regw;
        logic [1:0] flagw;
        bit         ill;
    } exp_t;

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input int nl, input int lpb);
        exp_t e;
        e.beats = 1; e.vec = 0; e.alu = 4'b0000; e.vecw = 0; e.vecidxw = 0;
        e.regw = 0; e.flagw = 2'b00; e.ill = 0;
        if (op == 2'b11) begin
            e.ill = 1; e.beats = 0;
        end else if (op != 2'b00) begin
            e.regw = ~op[1] & f[0];
        end else if (f[5] && f[4:1] == 4'b1101) begin
            e.vecidxw = 1;
        end else if (f[5] && f[4:1] == 4'b1110) begin
            e.regw = 1;
        end else if (f[4]) begin
            e.vec = 1; e.vecw = 1; e.beats = nl / lpb; e.alu = ALU_TAB[f[4:1]];
        end else begin
            e.regw = 1; e.alu = ALU_TAB[f[4:1]];
            e.flagw = {f[0], f[0] & (e.alu == 4'b0000 || e.alu == 4'b0001)};
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_beat4(input exp_t e, input int k);
        int m;
        m = e.vec ? (((1 << 1) - 1) << (k * 1)) : 0;
        return 32'({1'b1, 4'(m), e.alu, e.vecw, e.vecidxw, e.regw, e.flagw,
                    1'(k == e.beats - 1), 1'b0});
    endfunction

    function automatic logic [31:0] got_beat4();
        return 32'({iss_valid, iss_lane_mask, iss_ALUControl, iss_VecW, iss_VecIdxW,
                    iss_RegW, iss_FlagW, iss_last, illegal});
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word while the DUT is idle; one-cycle in_valid pulse
    task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; Op = op; Funct = f; Rd = rd;
        tick();
        in_valid = 1'b0;
    endtask

    // Issue one instruction and check every beat against the model
    task automatic run_check(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input bit rnd, input int stall_at, input int stall_len,
                             output int vcyc);
        exp_t e;
        int k = 0;
        int cyc = 0;
        int stalled = 0;
        e = model(op, f, 4, 1);
        vcyc = 0;
        send(op, f, rd);
        if (e.ill) begin
            chk("illegal_pulse", 32'({illegal, iss_valid}), 32'b10);
            tick();
            chk("illegal_clear", 32'({illegal, iss_valid}), 32'b00);
        end else begin
            while (k < e.beats && cyc < 200) begin
                if (rnd) iss_ready = ($urandom_range(0, 2) != 0);
                else if (k == stall_at && stalled < stall_len) begin
                    iss_ready = 1'b0; stalled++;
                end else iss_ready = 1'b1;
                #0;
                chk("beat", got_beat4(), exp_beat4(e, k));
                chk("beat_in_ready", 32'(in_ready), 32'(iss_ready && k == e.beats - 1));
                vcyc++;
                cyc++;
                if (iss_ready) k++;
                tick();
            end
            chk("beat_count", 32'(k), 32'(e.beats));
            chk("idle_after", 32'(iss_valid), 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        int vc;
        reset = 1'b0; in_valid = 1'b0; Op = '0; Funct = '0; Rd = '0; iss_ready = 1'b0;
        in_valid8 = 1'b0; Op8 = '0; Funct8 = '0; Rd8 = '0; iss_ready8 = 1'b0;
        tick(); tick();
        chk("reset_outputs", got_beat4(), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        tick();

        // VADD, no stall: 4 beats, masks 1,2,4,8, last on 4th
        run_check(2'b00, 6'b010000, 4'd1, 1'b0, -1, 0, vc);
        chk("vadd_valid_cycles", 32'(vc), 32'd4);

        // VADD with 3-cycle stall on beat 2
        run_check(2'b00, 6'b010000, 4'd2, 1'b0, 1, 3, vc);
        chk("vadd_stall_cycles", 32'(vc), 32'd7);

        // SUBS, MOVIDX, illegal, MOV, load, store
        run_check(2'b00, 6'b001011, 4'd3, 1'b0, -1, 0, vc);
        run_check(2'b00, 6'b111010, 4'b0010, 1'b0, -1, 0, vc);
        run_check(2'b11, 6'b000000, 4'd0, 1'b0, -1, 0, vc);
        run_check(2'b00, 6'b111100, 4'd4, 1'b0, -1, 0, vc);
        run_check(2'b01, 6'b000001, 4'b1111, 1'b0, -1, 0, vc);
        run_check(2'b10, 6'b000001, 4'd5, 1'b0, -1, 0, vc);

        // Back-to-back: SUBS accepted on the last VADD beat, issued with no bubble
        send(2'b00, 6'b010000, 4'd6);
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin in_valid = 1'b1; Op = 2'b00; Funct = 6'b001011; end
            #0;
            chk("b2b_in_ready", 32'(in_ready), 32'(k == 3));
            tick();
        end
        in_valid = 1'b0;
        e = model(2'b00, 6'b001011, 4, 1);
        chk("b2b_subs_beat", got_beat4(), exp_beat4(e, 0));
        tick();
        chk("b2b_idle", 32'(iss_valid), 32'd0);

        // Reset during beat 2 of a VADD abandons the instruction
        send(2'b00, 6'b010000, 4'd7);
        iss_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_valid", 32'(iss_valid), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_no_stale", 32'(iss_valid), 32'd0);
            tick();
        end

        // Randomized instructions with random backpressure
        for (int i = 0; i < 40; i++) begin
            run_check(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), 1'b1, -1, 0, vc);
        end

        // 8 lanes, 2 per beat: VXOR
        in_valid8 = 1'b1; Op8 = 2'b00; Funct8 = 6'b011110;
        #0;
        chk("w8_in_ready", 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 1'b0;
        iss_ready8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] m;
            m = 8'(3 << (2 * k));
            chk("w8_beat", 32'({iss_valid8, iss_lane_mask8, iss_ALUControl8, iss_VecW8, iss_last8}),
                32'({1'b1, m, 4'b1111, 1'b1, 1'(k == 3)}));
            tick();
        end
        chk("w8_idle", 32'(iss_valid8), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
